// File: rtl/sd_data_resp_gen.sv
// SD card-side write-data response generator on DAT0: CRC status token then busy signalling.
// Define SD_DATA_RESP_ABORT_EN to let SD_I_ABORT cut the busy-low phase short.
//
// state        | meaning
// S_IDLE       | line released, waiting for the host data end bit
// S_WAIT       | Ncrc turnaround, line still released
// S_TOKEN      | start bit, 3 status bits, end bit
// S_BSY_START  | busy start bit (low)
// S_BSY_LOW    | busy held low for the latched busy length
// S_BSY_END    | busy end bit (high), then release with a done pulse
module sd_data_resp_gen #(
   parameter int NCRC_DLY = 2,
   parameter int BSY_W    = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             SD_I_TRG,
   input  logic             SD_I_CRC_OK,
   input  logic             SD_I_FLASH_ERR,
   input  logic [BSY_W-1:0] SD_I_BSY_LEN,
   input  logic             SD_I_ABORT,
   output logic             SD_O_DAT0,
   output logic             SD_O_DAT0_OE,
   output logic             SD_O_BUSY,
   output logic             SD_O_DONE
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_TOKEN,
      S_BSY_START,
      S_BSY_LOW,
      S_BSY_END
   } state_t;

   localparam int                WAIT_W    = 3;
   localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(NCRC_DLY - 1);

   state_t             state_q, state_d;
   logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic [2:0]         tok_idx_q, tok_idx_d;
   logic [BSY_W-1:0]   bsy_cnt_q, bsy_cnt_d;
   logic [BSY_W-1:0]   bsy_len_q, bsy_len_d;
   logic               crc_ok_q, crc_ok_d;
   logic               flash_q, flash_d;
   logic               dat0_q, dat0_d;
   logic               oe_q, oe_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [2:0]         status;
   logic               abort_hit;

`ifdef SD_DATA_RESP_ABORT_EN
   assign abort_hit = SD_I_ABORT;
`else
   logic unused_abort;
   assign unused_abort = SD_I_ABORT;
   assign abort_hit    = 1'b0;
`endif

   assign status = crc_ok_q ? 3'b010 : 3'b101;

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      tok_idx_d  = tok_idx_q;
      bsy_cnt_d  = bsy_cnt_q;
      bsy_len_d  = bsy_len_q;
      crc_ok_d   = crc_ok_q;
      flash_d    = flash_q;
      unique case (state_q)
         S_IDLE: begin
            if (SD_I_TRG) begin
               crc_ok_d   = SD_I_CRC_OK;
               flash_d    = SD_I_FLASH_ERR;
               bsy_len_d  = SD_I_BSY_LEN;
               wait_cnt_d = WAIT_LOAD;
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (wait_cnt_q == '0) begin
               tok_idx_d = '0;
               state_d   = flash_q ? S_BSY_START : S_TOKEN;
            end else begin
               wait_cnt_d = wait_cnt_q - WAIT_W'(1);
            end
         end
         S_TOKEN: begin
            if (tok_idx_q == 3'd4) begin
               state_d = S_BSY_START;
            end else begin
               tok_idx_d = tok_idx_q + 3'd1;
            end
         end
         S_BSY_START: begin
            // Counter holds the low cycles still to go after the current one.
            if (bsy_len_q == '0) begin
               state_d = S_BSY_END;
            end else begin
               bsy_cnt_d = bsy_len_q - BSY_W'(1);
               state_d   = S_BSY_LOW;
            end
         end
         S_BSY_LOW: begin
            if ((bsy_cnt_q == '0) || abort_hit) begin
               bsy_cnt_d = '0;
               state_d   = S_BSY_END;
            end else begin
               bsy_cnt_d = bsy_cnt_q - BSY_W'(1);
            end
         end
         S_BSY_END: begin
            bsy_cnt_d = '0;
            state_d   = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so the pins are true flops.
   always_comb begin
      dat0_d = 1'b1;
      oe_d   = 1'b0;
      busy_d = (state_d != S_IDLE);
      done_d = (state_q == S_BSY_END);
      unique case (state_d)
         S_TOKEN: begin
            oe_d = 1'b1;
            case (tok_idx_d)
               3'd0:    dat0_d = 1'b0;
               3'd1:    dat0_d = status[2];
               3'd2:    dat0_d = status[1];
               3'd3:    dat0_d = status[0];
               default: dat0_d = 1'b1;
            endcase
         end
         S_BSY_START, S_BSY_LOW: begin
            oe_d   = 1'b1;
            dat0_d = 1'b0;
         end
         S_BSY_END: begin
            oe_d   = 1'b1;
            dat0_d = 1'b1;
         end
         default: begin
            oe_d   = 1'b0;
            dat0_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= S_IDLE;
         wait_cnt_q <= '0;
         tok_idx_q  <= '0;
         bsy_cnt_q  <= '0;
         bsy_len_q  <= '0;
         crc_ok_q   <= 1'b0;
         flash_q    <= 1'b0;
         dat0_q     <= 1'b1;
         oe_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         tok_idx_q  <= tok_idx_d;
         bsy_cnt_q  <= bsy_cnt_d;
         bsy_len_q  <= bsy_len_d;
         crc_ok_q   <= crc_ok_d;
         flash_q    <= flash_d;
         dat0_q     <= dat0_d;
         oe_q       <= oe_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign SD_O_DAT0    = dat0_q;
   assign SD_O_DAT0_OE = oe_q;
   assign SD_O_BUSY    = busy_q;
   assign SD_O_DONE    = done_q;

endmodule
